// File: rtl/pipe_if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack handshake and fills the IF/ID register.
// Optional branch-squash behaviour is compiled in with the IF_FLUSH_EN macro.
module pipe_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        nostall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] dinst,
    output logic [31:0] dpc4,
    output logic        dvalid
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_WAITR = 2'd2
    } state_t;

    state_t      state_r;
    logic        req_r;
    logic [31:0] pc_r;
    logic [31:0] dinst_r;
    logic [31:0] dpc4_r;
    logic        dvalid_r;
    logic [31:0] redir_pc_r;
    logic        redir_valid_r;
    logic [31:0] hold_word_r;
    logic [31:0] hold_pc4_r;

    logic        take_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;

    assign take_s     = dvalid_r & nostall & (pcsource != 2'b00);
    assign pc_plus4_s = pc_r + 32'd4;

    // Redirect target chosen by the ID control unit.
    always_comb begin
        target_s = jpc;
        case (pcsource)
            2'b01:   target_s = bpc;
            2'b10:   target_s = rpc;
            2'b11:   target_s = jpc;
            default: target_s = jpc;
        endcase
    end

    // A redirect decided this cycle wins over a pending one, which wins over sequential flow.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (take_s) begin
            next_pc_s = target_s;
        end else if (redir_valid_r) begin
            next_pc_s = redir_pc_r;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Fetch state machine with the PC, IF/ID register, hold buffer and pending redirect.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_FETCH;
            req_r         <= 1'b1;
            pc_r          <= RESET_PC;
            dinst_r       <= NOP_WORD;
            dpc4_r        <= 32'h0000_0000;
            dvalid_r      <= 1'b0;
            redir_pc_r    <= 32'h0000_0000;
            redir_valid_r <= 1'b0;
            hold_word_r   <= 32'h0000_0000;
            hold_pc4_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (nostall) begin
                            pc_r          <= next_pc_s;
                            dpc4_r        <= pc_plus4_s;
                            redir_valid_r <= 1'b0;
`ifdef IF_FLUSH_EN
                            if (take_s) begin
                                dinst_r  <= NOP_WORD;
                                dvalid_r <= 1'b0;
                            end else begin
                                dinst_r  <= imem_rdata;
                                dvalid_r <= 1'b1;
                            end
`else
                            dinst_r  <= imem_rdata;
                            dvalid_r <= 1'b1;
`endif
                        end else begin
                            // ID is stalled: park the word so the memory handshake can close.
                            hold_word_r <= imem_rdata;
                            hold_pc4_r  <= pc_plus4_s;
                            state_r     <= ST_HOLD;
                            req_r       <= 1'b0;
                        end
                    end else begin
                        if (nostall) begin
                            dinst_r  <= NOP_WORD;
                            dvalid_r <= 1'b0;
                            if (take_s) begin
                                redir_pc_r    <= target_s;
                                redir_valid_r <= 1'b1;
`ifdef IF_FLUSH_EN
                                state_r       <= ST_WAITR;
`endif
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (nostall) begin
                        pc_r          <= next_pc_s;
                        dpc4_r        <= hold_pc4_r;
                        redir_valid_r <= 1'b0;
                        state_r       <= ST_FETCH;
                        req_r         <= 1'b1;
`ifdef IF_FLUSH_EN
                        if (take_s) begin
                            dinst_r  <= NOP_WORD;
                            dvalid_r <= 1'b0;
                        end else begin
                            dinst_r  <= hold_word_r;
                            dvalid_r <= 1'b1;
                        end
`else
                        dinst_r  <= hold_word_r;
                        dvalid_r <= 1'b1;
`endif
                    end
                end
`ifdef IF_FLUSH_EN
                ST_WAITR: begin
                    // The stale request must still complete; its word is thrown away.
                    if (imem_ack) begin
                        pc_r          <= redir_pc_r;
                        redir_valid_r <= 1'b0;
                        state_r       <= ST_FETCH;
                    end
                    if (nostall) begin
                        dinst_r  <= NOP_WORD;
                        dvalid_r <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r <= ST_FETCH;
                    req_r   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign dinst     = dinst_r;
    assign dpc4      = dpc4_r;
    assign dvalid    = dvalid_r;

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Directed bench for pipe_if_fetch with a variable-latency instruction memory model.
// Expectations follow the IF_FLUSH_EN setting of the build.
module tb_pipe_if_fetch;

    logic        clock;
    logic        resetn;
    logic        nostall;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] dinst;
    logic [31:0] dpc4;
    logic        dvalid;

    logic [3:0]  lat;
    logic [3:0]  cnt;
    int          errors = 0;
    int          checks = 0;

    pipe_if_fetch dut (
        .clock      (clock),
        .resetn     (resetn),
        .nostall    (nostall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .dinst      (dinst),
        .dpc4       (dpc4),
        .dvalid     (dvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: word at address a is a ^ 32'h1234_0000, acked after lat waiting cycles.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cnt <= 4'd0;
        else if (imem_req && imem_ack) cnt <= 4'd0;
        else if (imem_req) cnt <= cnt + 4'd1;
    end
    assign imem_ack   = imem_req && (cnt >= lat);
    assign imem_rdata = imem_addr ^ 32'h1234_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        resetn = 1'b0; nostall = 1'b1; pcsource = 2'b00;
        bpc = 32'h0; rpc = 32'h0; jpc = 32'h0; lat = 4'd0;
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_dinst", dinst, 32'h0);
        chk("rst_dpc4", dpc4, 32'h0);
        chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
        resetn = 1'b1;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Zero-wait sequential stream.
        step();
        chk("seq1_addr", imem_addr, 32'h4);
        chk("seq1_dinst", dinst, 32'h1234_0000);
        chk("seq1_dpc4", dpc4, 32'h4);
        chk("seq1_dvalid", {31'd0, dvalid}, 32'd1);
        step();
        chk("seq2_addr", imem_addr, 32'h8);
        chk("seq2_dinst", dinst, 32'h1234_0004);
        chk("seq2_dpc4", dpc4, 32'h8);
        step();
        chk("seq3_addr", imem_addr, 32'hC);
        chk("seq3_dinst", dinst, 32'h1234_0008);
        chk("seq3_dpc4", dpc4, 32'hC);

        // Two-cycle ack latency gives two bubbles.
        lat = 4'd2;
        step();
        chk("lat_b1_dvalid", {31'd0, dvalid}, 32'd0);
        chk("lat_b1_dinst", dinst, 32'h0);
        chk("lat_b1_addr", imem_addr, 32'hC);
        step();
        chk("lat_b2_dvalid", {31'd0, dvalid}, 32'd0);
        chk("lat_b2_addr", imem_addr, 32'hC);
        step();
        chk("lat_done_dinst", dinst, 32'h1234_000C);
        chk("lat_done_dpc4", dpc4, 32'h10);
        chk("lat_done_addr", imem_addr, 32'h10);

        // Stall for three cycles while the ack for 0x10 arrives.
        lat = 4'd0; nostall = 1'b0;
        step();
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_dinst", dinst, 32'h1234_000C);
        chk("hold_pc", pc, 32'h10);
        step(); step();
        chk("hold3_dinst", dinst, 32'h1234_000C);
        chk("hold3_dvalid", {31'd0, dvalid}, 32'd1);
        chk("hold3_pc", pc, 32'h10);
        nostall = 1'b1;
        step();
        chk("rel_dinst", dinst, 32'h1234_0010);
        chk("rel_dpc4", dpc4, 32'h14);
        chk("rel_pc", pc, 32'h14);
        chk("rel_req", {31'd0, imem_req}, 32'd1);

        // beq at 0x10 now in ID, taken to 0x40.
        pcsource = 2'b01; bpc = 32'h40;
`ifdef IF_FLUSH_EN
        lat = 4'd1;
        step();
        pcsource = 2'b00;
        chk("br_squash_dvalid", {31'd0, dvalid}, 32'd0);
        chk("br_squash_dinst", dinst, 32'h0);
        chk("br_waitr_addr", imem_addr, 32'h14);
        chk("br_waitr_req", {31'd0, imem_req}, 32'd1);
        step();
        chk("br_tgt_addr", imem_addr, 32'h40);
        chk("br_tgt_dvalid", {31'd0, dvalid}, 32'd0);
        lat = 4'd0;
        step();
`else
        step();
        pcsource = 2'b00;
        chk("br_slot_dinst", dinst, 32'h1234_0014);
        chk("br_slot_dvalid", {31'd0, dvalid}, 32'd1);
        chk("br_tgt_addr", imem_addr, 32'h40);
        step();
`endif
        chk("br_tgt_dinst", dinst, 32'h1234_0040);
        chk("br_next_addr", imem_addr, 32'h44);

        // jr to the top of the address space, then wrap.
        pcsource = 2'b10; rpc = 32'hFFFF_FFFC;
        step();
        pcsource = 2'b00;
        chk("jr_addr", imem_addr, 32'hFFFF_FFFC);
`ifdef IF_FLUSH_EN
        chk("jr_dvalid", {31'd0, dvalid}, 32'd0);
`else
        chk("jr_slot_dinst", dinst, 32'h1234_0044);
`endif
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_dinst", dinst, 32'hEDCB_FFFC);
        chk("wrap_dpc4", dpc4, 32'h0);

        // Jump taken while the next fetch is still outstanding.
        lat = 4'd1; pcsource = 2'b11; jpc = 32'h100;
        step();
        pcsource = 2'b00;
        chk("pend_addr", imem_addr, 32'h0);
        chk("pend_dvalid", {31'd0, dvalid}, 32'd0);
        step();
        chk("pend_tgt_addr", imem_addr, 32'h100);
`ifdef IF_FLUSH_EN
        chk("pend_dvalid2", {31'd0, dvalid}, 32'd0);
`else
        chk("pend_dvalid2", {31'd0, dvalid}, 32'd1);
        chk("pend_dinst", dinst, 32'h1234_0000);
        chk("pend_dpc4", dpc4, 32'h4);
`endif

        // Asynchronous reset mid-run.
        #1 resetn = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_dvalid", {31'd0, dvalid}, 32'd0);
        chk("arst_dinst", dinst, 32'h0);
        chk("arst_req", {31'd0, imem_req}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_if_fetch.md
# pipe_if_fetch

Instruction-fetch stage for the five-stage pipelined CPU. It is the producer end of the ID-stage control interface: it owns the PC, issues requests to instruction memory over a req/ack handshake, and delivers instruction words into the IF/ID register. It obeys the `nostall` and `pcsource` signals returned by the ID control unit. Variable-latency memory and redirect bookkeeping are handled here, so ID sees either a valid instruction or a NOP.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_WORD`, default 32'h0000_0000: word placed in ID when no valid instruction is available (sll $0,$0,0).
- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `nostall`  in  1  from the ID control unit. 1 = ID consumes `dinst` this cycle; 0 = ID holds it.
- `pcsource`  in  2  from ID: 00 seq, 01 branch taken (`bpc`), 10 jr (`rpc`), 11 j/jal (`jpc`).
- `bpc`, `rpc`, `jpc`  in  32 each  redirect targets computed in ID.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_ack`  in  1  read data valid; may arrive in the same cycle as the request.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `pc`  out  32  current fetch PC.
- `dinst`  out  32  IF/ID instruction.
- `dpc4`  out  32  PC+4 of `dinst`, used by jal.
- `dvalid`  out  1  `dinst` is a real instruction, not a bubble.

## Operation
- Redirect condition: `take = dvalid & nostall & (pcsource != 00)`. Target: `bpc`, `rpc` or `jpc`, selected by `pcsource`.
- State machine states: FETCH, HOLD, WAITR.
  - **FETCH**: `imem_req`=1.
    - On ack with `nostall`=1: load `dinst`/`dpc4`/`dvalid`=1, and `pc` takes its next value.
    - On ack with `nostall`=0: capture the word in the hold buffer and go to HOLD.
    - No ack with `nostall`=1: load `NOP_WORD`, `dvalid`=0.
    - No ack with `nostall`=0: ID register unchanged.
  - **HOLD**: `imem_req`=0. When `nostall`=1, move the buffer into ID, advance `pc`, and return to FETCH.
  - **WAITR**: used only with `IF_FLUSH_EN` (see Configuration).
- Next `pc` on completion: `redir_valid ? redir_pc : pc+4`, where `redir_*` is the pending-redirect register.
- A `take` in any cycle sets `redir_pc`=target and `redir_valid`=1. It is consumed by the next fetch completion.
  - If `take` coincides with an ack, the target is used directly.
- Delay-slot semantics by default: the instruction fetched after a branch always executes.
- `imem_addr` and `imem_req` stay stable until ack. An outstanding request is never cancelled.
- Arithmetic is 32-bit wrap-around. `pc`+4 at 32'hFFFF_FFFC yields 0.

## Timing
- Reset (async, `resetn`=0):
  - `pc`=`RESET_PC`, `dinst`=`NOP_WORD`, `dpc4`=0, `dvalid`=0, `redir_valid`=0, state FETCH.
  - `imem_req`=1 from the first cycle after release.
- Zero-wait memory (same-cycle ack): one instruction per cycle, with ID latency of 1 clock from request.
- An N-cycle ack latency inserts N bubbles (`dvalid`=0), provided ID is not stalled.
- `nostall`=0 freezes `dinst`, `dpc4`, `dvalid`. `pc` freezes once the current fetch has completed.
- Reset during an outstanding fetch abandons it. An ack arriving after reset release for the old address is illegal; the memory must drop requests on reset.
- `take` and `nostall`=0 together is impossible (`take` is gated by `nostall`).

## Configuration
- `IF_FLUSH_EN` defined:
  - A `take` squashes the fetch that completes in the same cycle: ID gets `NOP_WORD` and `dvalid`=0.
  - If that fetch is still outstanding, enter WAITR. WAITR keeps `imem_req`=1 on the old address until ack, discards the word, then loads `pc`=`redir_pc` and returns to FETCH.
  - Branch penalty is 1 slot and there is no delay slot.
- `IF_FLUSH_EN` undefined: WAITR is absent and the delay-slot behaviour above applies.

## Test plan
- Reset with `RESET_PC`=0x0000_0000, zero-wait memory, `nostall`=1 -> `imem_addr` sequence 0,4,8,C; `dinst` follows one cycle later; `dpc4`=4,8,C.
- Ack latency of 2 cycles -> two `dvalid`=0 bubbles with `dinst`=`NOP_WORD` between instructions; `imem_addr` held during the wait.
- `nostall`=0 for 3 cycles while an ack arrives -> word held in HOLD, `imem_req`=0, `dinst` unchanged. On release the word enters ID and `pc` advances by 4.
- beq at 0x10 with `pcsource`=01, `bpc`=0x40, default build -> 0x14 executes (`dvalid`=1), then the fetch address is 0x40.
- Same beq with `IF_FLUSH_EN` and a 1-cycle ack latency -> the 0x14 word is discarded (`dvalid`=0), then `imem_addr`=0x40.
- jr with `rpc`=0xFFFF_FFFC followed by sequential fetch -> `pc` wraps to 0x0000_0000.
